// File: rtl/dm_cache_pkg.sv
// Shared sizing, FSM state and line type for the direct-mapped fill controller.
package dm_cache_pkg;
  localparam int ADDR_W     = 15;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 10;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int MEM_WORDS  = 32000;
  localparam int CNT_W      = 16;
  localparam int LINE_WORDS = 1 << OFFSET_W;
  localparam int LINES      = 1 << INDEX_W;

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, RESPOND} state_e;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;
endpackage

// File: rtl/dm_cache_store.sv
// Tag/valid/data arrays: combinational read, single-line synchronous fill.
module dm_cache_store
  import dm_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output line_t              rd_line,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  line_t              wr_line
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  line_t            data_q [LINES];

  always_ff @(posedge clk) begin
    if (!rst)    valid_q         <= '0;
    else if (we) valid_q[wr_idx] <= 1'b1;
  end

  // Tag/data carry no reset; a fill landing during reset is harmless but is blocked anyway.
  always_ff @(posedge clk) begin
    if (rst && we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];
endmodule

// File: rtl/dm_cache_fill_ctrl.sv
// Read-only direct-mapped cache controller: lookup, block fill from memory, hit/access counters.
module dm_cache_fill_ctrl
  import dm_cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic [ADDR_W-1:0]          cpu_addr,
  output logic                       cpu_valid,
  output logic [WORD_W-1:0]          cpu_rdata,
  output logic                       cpu_hit,
  output logic                       cpu_err,
  output logic                       busy,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ready,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_data,
  output logic [CNT_W-1:0]           access_count,
  output logic [CNT_W-1:0]           hit_count
);
  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cpu_valid_q, cpu_hit_q, cpu_err_q;
  logic [WORD_W-1:0]   cpu_rdata_q;
  logic [CNT_W-1:0]    access_count_q, hit_count_q;

  logic [OFFSET_W-1:0] off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                rd_valid, tag_hit, out_of_range, fill_we;
  logic [TAG_W-1:0]    rd_tag;
  line_t               rd_line, mem_line;

  assign off          = addr_q[OFFSET_W-1:0];
  assign idx          = addr_q[OFFSET_W +: INDEX_W];
  assign tag          = addr_q[ADDR_W-1 -: TAG_W];
  assign mem_line     = mem_data;
  assign tag_hit      = rd_valid && (rd_tag == tag);
  assign out_of_range = addr_q >= MEM_LIMIT;
  assign fill_we      = (state_q == MEM_REQ) && mem_ready;

  dm_cache_store u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (fill_we),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_line  (mem_line)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cpu_valid_q    <= 1'b0;
      cpu_hit_q      <= 1'b0;
      cpu_err_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      access_count_q <= '0;
      hit_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (out_of_range) begin
            cpu_valid_q <= 1'b1;
            cpu_err_q   <= 1'b1;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            state_q     <= RESPOND;
          end else if (tag_hit) begin
            cpu_valid_q <= 1'b1;
            cpu_err_q   <= 1'b0;
            cpu_hit_q   <= 1'b1;
            cpu_rdata_q <= rd_line[off];
            state_q     <= RESPOND;
          end else begin
            state_q <= MEM_REQ;
          end
        end
        MEM_REQ: if (mem_ready) begin
          // Requested word is forwarded straight from the returning line.
          cpu_valid_q <= 1'b1;
          cpu_err_q   <= 1'b0;
          cpu_hit_q   <= 1'b0;
          cpu_rdata_q <= mem_line[off];
          state_q     <= RESPOND;
        end
        RESPOND: begin
          cpu_valid_q <= 1'b0;
          if (!cpu_err_q) access_count_q <= access_count_q + CNT_W'(1);
          if (cpu_hit_q)  hit_count_q    <= hit_count_q + CNT_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_valid    = cpu_valid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_hit      = cpu_hit_q;
  assign cpu_err      = cpu_err_q;
  assign access_count = access_count_q;
  assign hit_count    = hit_count_q;
  assign busy         = state_q != IDLE;
  assign mem_req      = state_q == MEM_REQ;
  assign mem_addr     = mem_req ? {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
endmodule

// File: tb/tb_dm_cache_fill_ctrl.sv
// Bench for dm_cache_fill_ctrl: directed table, reset/stall sequences, random reads vs cache model.
module tb_dm_cache_fill_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [14:0]  cpu_addr;
  logic         cpu_valid, cpu_hit, cpu_err, busy, mem_req, mem_ready;
  logic [31:0]  cpu_rdata;
  logic [14:0]  mem_addr;
  logic [127:0] mem_data;
  logic [15:0]  access_count, hit_count;

  int checks = 0;
  int errors = 0;

  dm_cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .cpu_err(cpu_err),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_data(mem_data), .access_count(access_count), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Cache model: which tag each line holds, plus expected counters.
  logic        mv [1024];
  logic [2:0]  mt [1024];
  logic [15:0] m_acc, m_hc;

  typedef struct {
    logic [14:0] addr;
    int          lat;
    logic        exp_hit;
    logic        exp_err;
    logic        exp_mem;
    logic [14:0] exp_maddr;
    logic [15:0] exp_acc;
    logic [15:0] exp_hc;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] memword(input logic [14:0] a);
    return {a ^ 15'h2AAA, 2'b10, a};
  endfunction

  function automatic logic [127:0] block(input logic [14:0] ba);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = memword(ba + 15'(i));
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
    m_acc = '0;
    m_hc  = '0;
  endtask

  task automatic model_step(input logic [14:0] a, output logic eh, output logic ee);
    logic [9:0] ix;
    ix = a[11:2];
    ee = a >= 15'd32000;
    eh = !ee && mv[ix] && (mt[ix] == a[14:12]);
    if (!ee) begin
      m_acc++;
      if (eh) m_hc++;
      else begin
        mv[ix] = 1'b1;
        mt[ix] = a[14:12];
      end
    end
  endtask

  // One CPU read; memory answers after lat cycles of mem_req. vn/rn are cycle indices of cpu_valid/mem_ready.
  task automatic cpu_read(input logic [14:0] a, input int lat,
                          output logic [31:0] rd, output logic h, output logic e,
                          output logic sawm, output logic [14:0] ma, output int vn, output int rn);
    int rc;
    sawm = 1'b0; ma = '0; vn = -1; rn = -1; rc = 0; rd = '0; h = 1'b0; e = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (cpu_valid) begin
        vn = n; rd = cpu_rdata; h = cpu_hit; e = cpu_err;
        cpu_req = 1'b0;
        chk("mem_req_dropped", mem_req, 1'b0);
        break;
      end
      if (mem_req) begin
        if (!sawm) begin
          sawm = 1'b1;
          ma   = mem_addr;
        end else chk("mem_addr_stable", mem_addr, ma);
        chk("busy_in_mem_req", busy, 1'b1);
        rc++;
        if (rc == lat) begin
          mem_ready = 1'b1;
          mem_data  = block(mem_addr);
          rn = n;
        end
      end
    end
    if (vn < 0) begin
      cpu_req = 1'b0;
      chk("response_timeout", 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("valid_one_cycle", cpu_valid, 1'b0);
    chk("idle_after_resp", busy, 1'b0);
  endtask

  logic [31:0] rd;
  logic        h, e, sawm, eh, ee;
  logic [14:0] ma;
  int          vn, rn;

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0; mem_ready = 1'b0; mem_data = '0;
    model_reset();
    vecs[0] = '{15'h0010, 3, 1'b0, 1'b0, 1'b1, 15'h0010, 16'd1, 16'd0};
    vecs[1] = '{15'h0012, 1, 1'b1, 1'b0, 1'b0, 15'h0000, 16'd2, 16'd1};
    vecs[2] = '{15'h1010, 2, 1'b0, 1'b0, 1'b1, 15'h1010, 16'd3, 16'd1};
    vecs[3] = '{15'h0010, 1, 1'b0, 1'b0, 1'b1, 15'h0010, 16'd4, 16'd1};
    vecs[4] = '{15'h7D00, 1, 1'b0, 1'b1, 1'b0, 15'h0000, 16'd4, 16'd1};
    vecs[5] = '{15'h7CFF, 2, 1'b0, 1'b0, 1'b1, 15'h7CFC, 16'd5, 16'd1};
    vecs[6] = '{15'h7CFC, 1, 1'b1, 1'b0, 1'b0, 15'h0000, 16'd6, 16'd2};
    vecs[7] = '{15'h7FFF, 1, 1'b0, 1'b1, 1'b0, 15'h0000, 16'd6, 16'd2};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cpu_valid", cpu_valid, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cpu_hit", cpu_hit, 1'b0);
    chk("rst_cpu_err", cpu_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 15'h0);
    chk("rst_access_count", access_count, 16'h0);
    chk("rst_hit_count", hit_count, 16'h0);

    for (int j = 0; j < 8; j++) begin
      cpu_read(vecs[j].addr, vecs[j].lat, rd, h, e, sawm, ma, vn, rn);
      model_step(vecs[j].addr, eh, ee);
      chk("vec_hit", h, vecs[j].exp_hit);
      chk("vec_err", e, vecs[j].exp_err);
      chk("vec_rdata", rd, vecs[j].exp_err ? 32'h0 : memword(vecs[j].addr));
      chk("vec_mem_req_seen", sawm, vecs[j].exp_mem);
      if (vecs[j].exp_mem) begin
        chk("vec_mem_addr", ma, vecs[j].exp_maddr);
        chk("vec_miss_latency", vn, rn + 1);
      end else chk("vec_fast_latency", vn, 2);
      chk("vec_access_count", access_count, vecs[j].exp_acc);
      chk("vec_hit_count", hit_count, vecs[j].exp_hc);
    end

    // Reset in the middle of a fill: the late mem_ready must be ignored.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 15'h2010;
    for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
    chk("rst_seq_in_mem_req", mem_req, 1'b1);
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; mem_data = block(15'h2010);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rst_seq_busy", busy, 1'b0);
    chk("rst_seq_mem_req", mem_req, 1'b0);
    chk("rst_seq_access_count", access_count, 16'h0);
    chk("rst_seq_hit_count", hit_count, 16'h0);
    for (int n = 0; n < 4; n++) begin
      chk("rst_seq_no_valid", cpu_valid, 1'b0);
      @(negedge clk);
    end
    model_reset();
    cpu_read(15'h0010, 1, rd, h, e, sawm, ma, vn, rn);
    model_step(15'h0010, eh, ee);
    chk("post_rst_miss", h, 1'b0);
    chk("post_rst_mem_req", sawm, 1'b1);
    chk("post_rst_rdata", rd, memword(15'h0010));

    // Memory stalls for 20 cycles before answering.
    cpu_read(15'h2014, 21, rd, h, e, sawm, ma, vn, rn);
    model_step(15'h2014, eh, ee);
    chk("stall_mem_addr", ma, 15'h2014);
    chk("stall_latency", vn, rn + 1);
    chk("stall_req_cycles", rn - 2, 20);
    chk("stall_rdata", rd, memword(15'h2014));

    // Random reads over a few hot/conflicting lines plus the out-of-range region.
    for (int k = 0; k < 250; k++) begin
      int idxs[5] = '{4, 5, 'h33F, 'h340, 'h3FF};
      logic [14:0] a;
      int lat;
      a   = {3'($urandom_range(0, 7)), 10'(idxs[$urandom_range(0, 4)]), 2'($urandom_range(0, 3))};
      lat = $urandom_range(1, 4);
      cpu_read(a, lat, rd, h, e, sawm, ma, vn, rn);
      model_step(a, eh, ee);
      chk("rnd_hit", h, eh);
      chk("rnd_err", e, ee);
      chk("rnd_rdata", rd, ee ? 32'h0 : memword(a));
      chk("rnd_mem_req_seen", sawm, !ee && !eh);
      if (sawm) begin
        chk("rnd_mem_addr", ma, {a[14:2], 2'b00});
        chk("rnd_miss_latency", vn, rn + 1);
      end else chk("rnd_fast_latency", vn, 2);
      chk("rnd_access_count", access_count, m_acc);
      chk("rnd_hit_count", hit_count, m_hc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_cache_fill_ctrl.md
Name: dm_cache_fill_ctrl

Overview:
Direct-mapped, read-only cache controller that sits between the CPU word-read port and main memory's 128-bit block port. It is the requesting end of the main-memory block interface. It looks up a 15-bit word address in a 1K-line tag/valid/data store. On a miss it issues a block-aligned request to main memory, waits for the 4-word line, fills the line and returns the requested word. It also keeps access and hit counters for hit-rate measurement.

Parameters:
ADDR_W, 15, word address width
WORD_W, 32, CPU word width
OFFSET_W, 2, word-in-block bits (4 words per block)
INDEX_W, 10, cache index bits (1024 lines); tag width = ADDR_W-INDEX_W-OFFSET_W = 3
MEM_WORDS, 32000, valid main-memory words; addresses >= MEM_WORDS are illegal
CNT_W, 16, counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
cpu_req  in  1  read request; held high until cpu_valid
cpu_addr  in  ADDR_W  word address; stable while cpu_req high
cpu_valid  out  1  one-cycle response strobe
cpu_rdata  out  WORD_W  requested word, valid with cpu_valid
cpu_hit  out  1  response was a cache hit, valid with cpu_valid
cpu_err  out  1  address out of range, valid with cpu_valid
busy  out  1  controller not in IDLE
mem_req  out  1  block read request to main memory
mem_addr  out  ADDR_W  block-aligned address {tag,index,2'b00}
mem_ready  in  1  mem_data valid this cycle; completes request
mem_data  in  4*WORD_W  line; word i at bits [32*i+31:32*i]; word 0 = lowest address
access_count  out  CNT_W  completed legal accesses, wraps
hit_count  out  CNT_W  completed hits, wraps

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all 1024 valid bits cleared; all outputs 0, including both counters. Tag/data arrays are not reset. Reset aborts any in-flight miss; a late mem_ready is ignored.
- Address split: offset=addr[1:0], index=addr[11:2], tag=addr[14:12].
- IDLE: if cpu_req, latch cpu_addr and go to LOOKUP.
- LOOKUP:
  - If the latched address >= MEM_WORDS: go to RESPOND with err=1.
  - Else if valid[index] and tag matches: go to RESPOND with hit=1.
  - Else: go to MEM_REQ.
- MEM_REQ: mem_req=1 and mem_addr held constant. The request stays asserted until mem_ready. On the mem_ready cycle:
  - write mem_data to line[index], tag[index]=tag, valid[index]=1;
  - capture word[offset] from mem_data;
  - go to RESPOND.
  - mem_req drops the cycle after mem_ready. There is no timeout.
- RESPOND: cpu_valid=1 for exactly one cycle. cpu_rdata, cpu_hit and cpu_err are driven. Then return to IDLE. cpu_rdata=0 when err.
- Counters update in RESPOND:
  - access_count +1 unless err;
  - hit_count +1 if hit;
  - both wrap modulo 2^CNT_W.
- Latency: hit → cpu_valid 2 cycles after the IDLE cycle that samples cpu_req. Miss → cpu_valid 1 cycle after mem_ready.
- cpu_req still high in RESPOND is not a new request. A new request is only sampled in IDLE, so back-to-back requests cost at least 3 cycles each.
- mem_ready outside MEM_REQ is ignored.
- Addresses 31996..31999 form a legal final block. A block-aligned address whose block straddles MEM_WORDS cannot occur, since 32000 is a multiple of 4.
- Outputs cpu_* are registered. The mem_* outputs are decoded from state and latched address registers.

Decomposition:
- Package dm_cache_pkg holds:
  - ADDR_W, WORD_W, OFFSET_W, INDEX_W, TAG_W, MEM_WORDS;
  - state enum {IDLE, LOOKUP, MEM_REQ, RESPOND};
  - line_t as a packed array of 4 words.
- One sub-module, dm_cache_store, holds the tag/valid/data arrays:
  - combinational read by index;
  - synchronous single-line write;
  - synchronous valid clear on reset.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then read 0x0010 with memory returning words {A3,A2,A1,A0} after 3 cycles → mem_addr=0x0010, cpu_rdata=A0, cpu_hit=0, access_count=1, hit_count=0.
- Then read 0x0012 → no mem_req; cpu_valid 2 cycles after req; cpu_rdata=A2, cpu_hit=1, hit_count=1.
- Read 0x1010 (same index 4, tag 1) then 0x0010 → both miss; second re-fetches block 0x0010 (conflict eviction); hit_count unchanged.
- Read 0x7D00 (32000) → cpu_err=1, cpu_rdata=0, no mem_req, access_count unchanged. Read 0x7CFF (31999) → mem_addr=0x7CFC, word 3 returned.
- Assert rst=0 during MEM_REQ, release, pulse mem_ready → no cpu_valid, busy=0, counters 0. Re-read 0x0010 → miss (valid cleared).
- Hold mem_ready low for 20 cycles → mem_req and mem_addr stable throughout, busy=1. On mem_ready → cpu_valid on the next cycle.
